// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults and bank-select encoding for the ping-pong RAM
package mem_pkg;

    localparam int MEM_DATA_BIT_DEF = 64;
    localparam int MEM_DEPTH_DEF    = 1024;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/mem_db_ram_if.sv
// rtl/mem_db_ram_if.sv - producer/consumer bus of the ping-pong RAM
interface mem_db_ram_if
    import mem_pkg::*;
#(
    parameter int DATA_BIT = MEM_DATA_BIT_DEF,
    parameter int DEPTH    = MEM_DEPTH_DEF,
    localparam int ADDR_BIT = (DEPTH > 1) ? $clog2(DEPTH) : 1
);

    logic                sw;
    logic [ADDR_BIT-1:0] waddr;
    logic                wen;
    logic [DATA_BIT-1:0] wdata;
    logic [ADDR_BIT-1:0] raddr;
    logic                ren;
    logic [DATA_BIT-1:0] rdata;

    modport master (
        output sw, waddr, wen, wdata, raddr, ren,
        input  rdata
    );

    modport slave (
        input  sw, waddr, wen, wdata, raddr, ren,
        output rdata
    );

endinterface

// File: rtl/mem_dp_bank.sv
// rtl/mem_dp_bank.sv - one bank: simple dual-port RAM with registered, async-reset read port
module mem_dp_bank
    import mem_pkg::*;
#(
    parameter int DATA_BIT = MEM_DATA_BIT_DEF,
    parameter int DEPTH    = MEM_DEPTH_DEF,
    localparam int ADDR_BIT = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  logic [ADDR_BIT-1:0] waddr,
    input  logic [DATA_BIT-1:0] wdata,
    input  logic                ren,
    input  logic [ADDR_BIT-1:0] raddr,
    output logic [DATA_BIT-1:0] rdata
);

    logic [DATA_BIT-1:0] mem [DEPTH];

    // Array kept free of reset so it maps onto block RAM; rst only gates the write.
    always_ff @(posedge clk) begin
        if (!rst && wen && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= (int'(raddr) < DEPTH) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/mem_db_ram.sv
// rtl/mem_db_ram.sv - ping-pong RAM: write one bank while the other is read
// Optional MEM_DB_OUT_REG_EN adds a second output register stage (latency 2).
module mem_db_ram
    import mem_pkg::*;
#(
    parameter int DATA_BIT = MEM_DATA_BIT_DEF,
    parameter int DEPTH    = MEM_DEPTH_DEF
) (
    input logic          clk,
    input logic          rst,
    mem_db_ram_if.slave  bus
);

    logic                wbank;
    logic                rbank;
    logic                rbank_q;
    logic [DATA_BIT-1:0] rd0;
    logic [DATA_BIT-1:0] rd1;
    logic [DATA_BIT-1:0] rd_s1;

    assign wbank = ~bus.sw;
    assign rbank = bus.sw;

    mem_dp_bank #(.DATA_BIT(DATA_BIT), .DEPTH(DEPTH)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .wen   (bus.wen & (wbank == BANK0)),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .ren   (bus.ren & (rbank == BANK0)),
        .raddr (bus.raddr),
        .rdata (rd0)
    );

    mem_dp_bank #(.DATA_BIT(DATA_BIT), .DEPTH(DEPTH)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .wen   (bus.wen & (wbank == BANK1)),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .ren   (bus.ren & (rbank == BANK1)),
        .raddr (bus.raddr),
        .rdata (rd1)
    );

    // Remember which bank produced the last read so idle cycles keep showing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbank_q <= BANK0;
        end else if (bus.ren) begin
            rbank_q <= rbank;
        end
    end

    assign rd_s1 = (rbank_q == BANK1) ? rd1 : rd0;

`ifdef MEM_DB_OUT_REG_EN
    logic                ren_q;
    logic [DATA_BIT-1:0] rd_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_q <= 1'b0;
            rd_s2 <= '0;
        end else begin
            ren_q <= bus.ren;
            if (ren_q) begin
                rd_s2 <= rd_s1;
            end
        end
    end

    assign bus.rdata = rd_s2;
`else
    assign bus.rdata = rd_s1;
`endif

endmodule

// File: tb/tb_mem_db_ram.sv
// tb/tb_mem_db_ram.sv - scoreboard bench for mem_db_ram (latency follows MEM_DB_OUT_REG_EN)
module tb_mem_db_ram;

    localparam int DATA_BIT = 64;
    localparam int DEPTH    = 1000;
    localparam int ADDR_BIT = $clog2(DEPTH);
`ifdef MEM_DB_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_db_ram_if #(.DATA_BIT(DATA_BIT), .DEPTH(DEPTH)) bus ();

    mem_db_ram #(.DATA_BIT(DATA_BIT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [63:0] data;
    } sb_t;

    sb_t         sbq[$];
    logic [63:0] m0[int];
    logic [63:0] m1[int];
    logic [63:0] rd_model;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic s, input int ra);
        if (ra >= DEPTH) return 64'h0;
        if (s) return m1.exists(ra) ? m1[ra] : 64'hx;
        return m0.exists(ra) ? m0[ra] : 64'hx;
    endfunction

    task automatic cyc(input logic s, input logic we, input int wa, input logic [63:0] wd,
                       input logic re, input int ra, input string tag);
        sb_t e;
        bus.sw    = s;
        bus.wen   = we;
        bus.waddr = ADDR_BIT'(wa);
        bus.wdata = wd;
        bus.ren   = re;
        bus.raddr = ADDR_BIT'(ra);
        if (re) rd_model = model_read(s, ra);
        if (we && wa < DEPTH) begin
            if (s) m0[wa] = wd;
            else   m1[wa] = wd;
        end
        e.tag  = tag;
        e.data = rd_model;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == LAT) begin
            e = sbq.pop_front();
            check(e.tag, bus.rdata, e.data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 64'h0, 1'b0, 0, "idle");
    endtask

    task automatic do_reset(input logic s, input int wa, input logic [63:0] wd);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", bus.rdata, 64'h0);
        bus.sw    = s;
        bus.wen   = 1'b1;
        bus.waddr = ADDR_BIT'(wa);
        bus.wdata = wd;
        bus.ren   = 1'b1;
        bus.raddr = ADDR_BIT'(wa);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.sw = ~bus.sw;
            check("rst_hold", bus.rdata, 64'h0);
        end
        rst = 1'b0;
        sbq.delete();
        rd_model = 64'h0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.sw    = 1'b1;
        bus.wen   = 1'b1;
        bus.waddr = ADDR_BIT'(3);
        bus.wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.ren   = 1'b1;
        bus.raddr = ADDR_BIT'(3);
        rd_model  = 64'h0;
        #1;
        check("rst_t0", bus.rdata, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_t0_hold", bus.rdata, 64'h0);
        rst = 1'b0;

        cyc(1'b1, 1'b1, 40, 64'h87654321, 1'b0, 0, "t2_wr");
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b1, 40, "t2_rd");
        for (int i = 0; i < 5; i++) cyc(i[0], 1'b1, 200 + i, 64'hBEEF + 64'(i), 1'b0, i, "t6_hold");

        cyc(1'b0, 1'b1, 30, 64'h12345678, 1'b0, 0, "t3_wr");
        cyc(1'b1, 1'b0, 0, 64'h0, 1'b1, 30, "t3_rd");

        cyc(1'b1, 1'b1, 5, 64'hAAAA, 1'b0, 0, "t4_wr0");
        cyc(1'b0, 1'b1, 5, 64'h5555, 1'b0, 0, "t4_wr1");
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b1, 5, "t4_rd0");
        cyc(1'b1, 1'b0, 0, 64'h0, 1'b1, 5, "t4_rd1");

        for (int i = 0; i < 16; i++)
            cyc(i[0], 1'b1, 100, 64'hC0DE_0000 + 64'(i), (i > 0), 100, "t5_pingpong");

        cyc(1'b1, 1'b1, 1010, 64'hDEAD, 1'b0, 0, "oor_wr");
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b1, 1010, "oor_rd");
        cyc(1'b1, 1'b0, 0, 64'h0, 1'b1, 100, "oor_recover");

        cyc(1'b1, 1'b1, 7, 64'h1111, 1'b0, 0, "t1_prewr");
        idle(LAT + 1);
        do_reset(1'b1, 7, 64'h2222);
        cyc(1'b0, 1'b0, 0, 64'h0, 1'b1, 7, "t1_no_spurious");
        cyc(1'b1, 1'b0, 0, 64'h0, 1'b1, 30, "t1_post_rst");
        idle(LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
